// File: rtl/register_bank.sv
// rtl/register_bank.sv - multi-read-port register file with busy scoreboard and debug dump port
//
// Purpose:
//   NREGS x XLEN architectural register file with NREAD combinational read
//   ports, optional hardwired-zero x0, optional same-cycle write-to-read
//   bypass, a per-register busy scoreboard for hazard detection and a
//   handshaked serial dump of the whole file.
//
// Ports:
//   clock        in   system clock, all state updates on the rising edge
//   reset        in   synchronous active-low reset
//   rd_addr      in   NREAD*AW   read addresses, port i at [i*AW +: AW]
//   rd_data      out  NREAD*XLEN read data, port i at [i*XLEN +: XLEN]
//   rd_busy      out  NREAD      busy flag of each addressed register
//   wr_en        in   write strobe
//   wr_addr      in   AW         write address
//   wr_data      in   XLEN       write data
//   claim_en     in   mark a register as having a pending write
//   claim_addr   in   AW         register to mark busy
//   dump_start   in   request a full register dump
//   dump_active  out  dump in progress
//   dump_valid   out  dump beat valid
//   dump_ready   in   consumer accepts beat
//   dump_addr    out  AW         index of the current beat
//   dump_data    out  XLEN       register value of the current beat

module register_bank #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 16,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  claim_en,
  input  logic [AW-1:0]         claim_addr,
  input  logic                  dump_start,
  output logic                  dump_active,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [AW-1:0]         dump_addr,
  output logic [XLEN-1:0]       dump_data
);

  localparam logic ZR = (ZERO_REG != 0);
  localparam logic BP = (BYPASS != 0);
  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  logic [XLEN-1:0] regs_q [NREGS];
  logic [NREGS-1:0] busy_q;

  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  logic write_ok;
  logic claim_ok;

  // x0 writes and claims are dropped when x0 is hardwired.
  assign write_ok = wr_en && !(ZR && (wr_addr == '0));
  assign claim_ok = claim_en && !(ZR && (claim_addr == '0));

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [AW-1:0] a;
    logic          is_zero;
    logic          wr_hit;
    logic          claim_hit;

    assign a         = rd_addr[g*AW +: AW];
    assign is_zero   = ZR && (a == '0);
    assign wr_hit    = BP && wr_en && (wr_addr == a);
    assign claim_hit = claim_en && (claim_addr == a);

    assign rd_data[g*XLEN +: XLEN] = is_zero ? '0 :
                                     wr_hit  ? wr_data : regs_q[a];
    // A completing write hides the busy bit unless a new producer claims the
    // same register in this very cycle.
    assign rd_busy[g] = busy_q[a] & ~(wr_hit & ~claim_hit);
  end

  // ---------------------------------------------------------------------------
  // Storage and scoreboard
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs_q[r] <= '0;
      end
      busy_q <= '0;
    end else begin
      if (write_ok) begin
        regs_q[wr_addr] <= wr_data;
      end
      if (wr_en) begin
        busy_q[wr_addr] <= 1'b0;
      end
      // Placed after the clear so that a same-cycle claim wins.
      if (claim_ok) begin
        busy_q[claim_addr] <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Dump FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (dump_start) begin
          state_d = S_SEND;
          idx_d   = '0;
        end
      end
      S_SEND: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  logic            dump_zero;
  logic            dump_hit;
  logic [XLEN-1:0] dump_value;

  // Beat data follows the same bypass path as the read ports, so a write to
  // the stalled index shows up on the beat immediately.
  assign dump_zero  = ZR && (idx_q == '0);
  assign dump_hit   = BP && wr_en && (wr_addr == idx_q);
  assign dump_value = dump_zero ? '0 :
                      dump_hit  ? wr_data : regs_q[idx_q];

  assign dump_active = (state_q == S_SEND);
  assign dump_valid  = (state_q == S_SEND);
  assign dump_addr   = idx_q;
  assign dump_data   = (state_q == S_SEND) ? dump_value : '0;

endmodule
